rlbp_code_rx: RTL and testbench

- Receiver and deserializer for the serial RLBP code stream produced by the rlbp core's parallel-to-serial stage.
- Drives that stage's enable, samples its serial output LSB first, and checks its ready flag.
- Presents the reassembled code word to downstream logic (wishbone/LA readback) over a valid/ack handshake.
- Sits beside the rlbp core in the same clock domain.

---
 rtl/rlbp_code_rx_pkg.sv | 16 +
 rtl/rlbp_rx_shreg.sv | 38 +++
 rtl/rlbp_code_rx.sv | 136 +++++++++++++
 tb/tb_rlbp_code_rx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rlbp_code_rx_pkg.sv
// Shared definitions for the RLBP serial code receiver.
package rlbp_code_rx_pkg;

    localparam int unsigned DefWidth      = 8;
    localparam int unsigned DefRdyTimeout = 4;
    localparam int unsigned DefCntW       = 8;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArm     = 3'd1,
        StShift   = 3'd2,
        StWaitRdy = 3'd3,
        StHold    = 3'd4
    } state_e;

endpackage

// File: rtl/rlbp_rx_shreg.sv
// Indexed-write capture register: one bit written per enabled edge at idx_i.
module rlbp_rx_shreg
    import rlbp_code_rx_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (we_i) begin
            q_d[idx_i] = bit_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/rlbp_code_rx.sv
// Receives one LSB-first code frame from the P2S stage and offers it downstream
// over a valid/ack handshake. Outputs are registers or pure state decodes.
module rlbp_code_rx
    import rlbp_code_rx_pkg::*;
#(
    parameter int unsigned WIDTH       = DefWidth,
    parameter int unsigned RDY_TIMEOUT = DefRdyTimeout,
    parameter int unsigned CNT_W       = DefCntW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             s_data_i,
    input  logic             src_ready_i,
    output logic             en_o,
    output logic [WIDTH-1:0] code_o,
    output logic             code_valid_o,
    input  logic             code_ack_i,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] frame_cnt_o
);

    localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned TmoW = $clog2(RDY_TIMEOUT + 1);

    state_e           state_d, state_q;
    logic [BitW-1:0]  bitcnt_d, bitcnt_q;
    logic [TmoW-1:0]  tmo_d, tmo_q;
    logic             err_d, err_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [WIDTH-1:0] code_d, code_q;
    logic [WIDTH-1:0] sh_q;
    logic             sh_clr, sh_we;

    rlbp_rx_shreg #(
        .WIDTH (WIDTH),
        .IDX_W (BitW)
    ) u_shreg (
        .clk_i (clk),
        .rst_i (reset),
        .clr_i (sh_clr),
        .we_i  (sh_we),
        .idx_i (bitcnt_q),
        .bit_i (s_data_i),
        .q_o   (sh_q)
    );

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        sh_clr   = 1'b0;
        sh_we    = 1'b0;
        if (abort_i) begin
            state_d  = StIdle;
            bitcnt_d = '0;
            tmo_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_d = StArm;
                        err_d   = 1'b0;
                        sh_clr  = 1'b1;
                    end
                end
                StArm: begin
                    state_d  = StShift;
                    bitcnt_d = '0;
                    tmo_d    = '0;
                end
                StShift: begin
                    sh_we    = 1'b1;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == BitW'(WIDTH - 1)) begin
                        bitcnt_d = '0;
                        state_d  = StWaitRdy;
                    end
                end
                StWaitRdy: begin
                    // The frame is complete in sh_q here; latch it so code_o only moves on entry to HOLD.
                    if (src_ready_i) begin
                        state_d = StHold;
                        code_d  = sh_q;
                        tmo_d   = '0;
                    end else if (tmo_q == TmoW'(RDY_TIMEOUT - 1)) begin
                        state_d = StHold;
                        code_d  = sh_q;
                        err_d   = 1'b1;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                StHold: begin
                    if (code_ack_i) begin
                        state_d = StIdle;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            bitcnt_q <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
        end
    end

    assign en_o         = (state_q == StArm) || (state_q == StShift) || (state_q == StWaitRdy);
    assign busy_o       = (state_q != StIdle);
    assign code_valid_o = (state_q == StHold);
    assign code_o       = code_q;
    assign err_o        = err_q;
    assign frame_cnt_o  = cnt_q;

endmodule

// File: tb/tb_rlbp_code_rx.sv
// Directed bench for rlbp_code_rx with a behavioural P2S source model.
module tb_rlbp_code_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       s_data_i = 1'b0;
    logic       src_ready_i = 1'b0;
    logic       en_o;
    logic [7:0] code_o;
    logic       code_valid_o;
    logic       code_ack_i = 1'b0;
    logic       busy_o;
    logic       err_o;
    logic [7:0] frame_cnt_o;

    int         n_cmp = 0;
    int         n_err = 0;

    logic [7:0] word = 8'h00;
    int         idx = 0;
    logic       rdy_en = 1'b1;

    rlbp_code_rx #(
        .WIDTH       (8),
        .RDY_TIMEOUT (4),
        .CNT_W       (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .s_data_i     (s_data_i),
        .src_ready_i  (src_ready_i),
        .en_o         (en_o),
        .code_o       (code_o),
        .code_valid_o (code_valid_o),
        .code_ack_i   (code_ack_i),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .frame_cnt_o  (frame_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the source model reacts to the en_o level seen by that edge.
    task automatic cyc();
        logic en_now;
        en_now = en_o;
        @(posedge clk);
        #1;
        if (en_now) begin
            if (idx < 8) begin
                s_data_i = word[idx];
                idx++;
            end else if (rdy_en) begin
                src_ready_i = 1'b1;
            end
        end else begin
            idx = 0;
            src_ready_i = 1'b0;
        end
    endtask

    task automatic run_frame();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        repeat (11) cyc();
    endtask

    initial begin
        #3 reset = 1'b1;
        #1;
        chk("rst_en", en_o, 0);
        chk("rst_valid", code_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc();
        chk("rel_code", code_o, 0);
        chk("rel_err", err_o, 0);
        chk("rel_cnt", frame_cnt_o, 0);
        for (int i = 0; i < 20; i++) begin
            chk("idle_en", en_o, 0);
            chk("idle_busy", busy_o, 0);
            cyc();
        end

        // Nominal frame, ack tied high
        word = 8'hA5;
        code_ack_i = 1'b1;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            chk("nom_en", en_o, 1);
            chk("nom_valid_early", code_valid_o, 0);
            cyc();
        end
        chk("nom_valid", code_valid_o, 1);
        chk("nom_code", code_o, 8'hA5);
        chk("nom_err", err_o, 0);
        chk("nom_en_hold", en_o, 0);
        cyc();
        chk("nom_valid_drop", code_valid_o, 0);
        chk("nom_cnt", frame_cnt_o, 1);
        chk("nom_busy", busy_o, 0);

        // Held handshake with ignored start pulses
        word = 8'h3C;
        code_ack_i = 1'b0;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        repeat (10) cyc();
        for (int k = 0; k < 6; k++) begin
            code_ack_i = (k == 5);
            start_i = (k == 2);
            chk("hold_valid", code_valid_o, 1);
            chk("hold_code", code_o, 8'h3C);
            chk("hold_cnt", frame_cnt_o, 1);
            cyc();
        end
        start_i = 1'b0;
        chk("hold_valid_drop", code_valid_o, 0);
        chk("hold_cnt_inc", frame_cnt_o, 2);
        cyc();
        chk("hold_start_ignored", busy_o, 0);

        // Ready timeout
        word = 8'h5A;
        rdy_en = 1'b0;
        code_ack_i = 1'b0;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        repeat (9) cyc();
        for (int i = 0; i < 4; i++) begin
            chk("tmo_wait_en", en_o, 1);
            chk("tmo_wait_valid", code_valid_o, 0);
            chk("tmo_wait_err", err_o, 0);
            cyc();
        end
        chk("tmo_err", err_o, 1);
        chk("tmo_valid", code_valid_o, 1);
        chk("tmo_code", code_o, 8'h5A);
        chk("tmo_en", en_o, 0);
        code_ack_i = 1'b1;
        cyc();
        chk("tmo_cnt", frame_cnt_o, 3);
        chk("tmo_err_sticky", err_o, 1);
        rdy_en = 1'b1;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        chk("tmo_err_clr", err_o, 0);
        repeat (11) cyc();
        chk("tmo_next_cnt", frame_cnt_o, 4);
        chk("tmo_next_err", err_o, 0);

        // Abort at the 4th sampled bit
        word = 8'h81;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        repeat (4) cyc();
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        chk("abt_busy", busy_o, 0);
        chk("abt_en", en_o, 0);
        chk("abt_valid", code_valid_o, 0);
        chk("abt_cnt", frame_cnt_o, 4);
        chk("abt_code", code_o, 8'h5A);
        repeat (12) begin
            cyc();
            chk("abt_no_valid", code_valid_o, 0);
        end
        start_i = 1'b1;
        abort_i = 1'b1;
        cyc();
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("abt_start_tie", busy_o, 0);
        word = 8'hFF;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        repeat (10) cyc();
        chk("ff_valid", code_valid_o, 1);
        chk("ff_code", code_o, 8'hFF);
        cyc();
        chk("ff_cnt", frame_cnt_o, 5);

        // Counter wrap, then async reset mid-SHIFT
        word = 8'h69;
        repeat (250) run_frame();
        chk("wrap_pre", frame_cnt_o, 255);
        run_frame();
        chk("wrap_cnt", frame_cnt_o, 0);
        chk("wrap_code", code_o, 8'h69);
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        repeat (3) cyc();
        chk("shift_busy", busy_o, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_en", en_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_valid", code_valid_o, 0);
        chk("arst_code", code_o, 0);
        #2 reset = 1'b0;
        repeat (12) begin
            cyc();
            chk("arst_no_valid", code_valid_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
